local_history_predictor: RTL and testbench

Two-level local-history branch predictor. It is the parametrised successor to the 3-bit branch history table. Per-branch shift-register histories (BHT) index a pattern history table (PHT) of saturating counters, and the block returns a registered taken/not-taken prediction plus the history it used. It sits in the fetch stage: the prediction port is driven from fetch, and the update port is driven from branch resolution in the execute/commit path.

---
 rtl/local_history_predictor.sv | 125 ++++++++++++
 tb/tb_local_history_predictor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/local_history_predictor.sv
// Two-level local-history branch predictor: per-branch history (BHT) indexes saturating counters (PHT).
// Define BP_BYPASS_EN to forward a same-cycle update into the prediction path.
module local_history_predictor #(
  parameter int BHT_IDX_W = 3,
  parameter int HIST_W    = 3,
  parameter int CTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pred_valid,
  input  logic [BHT_IDX_W-1:0] pred_idx,
  output logic                 pred_out_valid,
  output logic                 pred_taken,
  output logic [HIST_W-1:0]    pred_hist,
  input  logic                 upd_valid,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic [HIST_W-1:0]    upd_hist,
  input  logic                 upd_taken,
  output logic                 ready
);
  localparam int PHT_IDX_W = HIST_W + BHT_IDX_W;
  localparam int BHT_DEPTH = 2**BHT_IDX_W;
  localparam int PHT_DEPTH = 2**PHT_IDX_W;
  localparam logic [CTR_W-1:0]     CTR_WNT  = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0]     CTR_MAX  = '1;
  localparam logic [CTR_W-1:0]     CTR_MIN  = '0;
  localparam logic [PHT_IDX_W-1:0] PTR_LAST = '1;

  typedef enum logic {INIT, READY} state_e;

  state_e                 state_q, state_d;
  logic [PHT_IDX_W-1:0]   init_ptr_q, init_ptr_d;
  logic [HIST_W-1:0]      bht_q [BHT_DEPTH];
  logic [CTR_W-1:0]       pht_q [PHT_DEPTH];

  logic                   pred_vld_q;
  logic                   pred_taken_q;
  logic [HIST_W-1:0]      pred_hist_q;

  logic                   upd_en, pred_en;
  logic [PHT_IDX_W-1:0]   upd_addr, pr_addr;
  logic [CTR_W-1:0]       upd_ctr, upd_ctr_new, pr_ctr;
  logic [HIST_W-1:0]      upd_bht_new, pr_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == PTR_LAST) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign ready   = (state_q == READY);
  assign upd_en  = ready && upd_valid;
  assign pred_en = ready && pred_valid;

  // Update trains the counter addressed by the history the branch was predicted with.
  always_comb begin
    upd_addr    = {upd_hist, upd_idx};
    upd_ctr     = pht_q[upd_addr];
    upd_ctr_new = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_new = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != CTR_MIN) upd_ctr_new = upd_ctr - 1'b1;
    end
    upd_bht_new = {bht_q[upd_idx][HIST_W-2:0], upd_taken};
  end

  always_comb begin
    pr_hist = bht_q[pred_idx];
`ifdef BP_BYPASS_EN
    if (upd_en && (upd_idx == pred_idx)) pr_hist = upd_bht_new;
`endif
    pr_addr = {pr_hist, pred_idx};
    pr_ctr  = pht_q[pr_addr];
`ifdef BP_BYPASS_EN
    if (upd_en && (pr_addr == upd_addr)) pr_ctr = upd_ctr_new;
`endif
  end

  // Table contents are established by the INIT sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      pht_q[init_ptr_q]                  <= CTR_WNT;
      bht_q[init_ptr_q[BHT_IDX_W-1:0]]   <= '0;
    end else if (upd_valid) begin
      pht_q[upd_addr] <= upd_ctr_new;
      bht_q[upd_idx]  <= upd_bht_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_vld_q   <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_hist_q  <= '0;
    end else begin
      pred_vld_q <= pred_en;
      if (pred_en) begin
        pred_taken_q <= pr_ctr[CTR_W-1];
        pred_hist_q  <= pr_hist;
      end
    end
  end

  assign pred_out_valid = pred_vld_q;
  assign pred_taken     = pred_taken_q;
  assign pred_hist      = pred_hist_q;
endmodule

// File: tb/tb_local_history_predictor.sv
// Scoreboard bench for local_history_predictor: predictions queue expected {taken,hist}, a monitor pops them.
module tb_local_history_predictor;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid;
  logic [2:0] pred_idx;
  logic       pred_out_valid;
  logic       pred_taken;
  logic [2:0] pred_hist;
  logic       upd_valid;
  logic [2:0] upd_idx;
  logic [2:0] upd_hist;
  logic       upd_taken;
  logic       ready;

  int tests = 0;
  int fails = 0;
  logic [3:0] expq [$];

  always #5 clk = ~clk;

  local_history_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_idx(pred_idx),
    .pred_out_valid(pred_out_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_hist(upd_hist), .upd_taken(upd_taken),
    .ready(ready)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && pred_out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pred: got taken=%0b hist=%03b with nothing expected at %0t",
                 pred_taken, pred_hist, $time);
      end else begin
        chk("pred{taken,hist}", {28'd0, pred_taken, pred_hist}, {28'd0, expq.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pred(input logic [2:0] idx, input logic t, input logic [2:0] h);
    pred_valid = 1'b1;
    pred_idx   = idx;
    expq.push_back({t, h});
    cyc();
    pred_valid = 1'b0;
  endtask

  task automatic upd(input logic [2:0] idx, input logic [2:0] h, input logic t);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_hist  = h;
    upd_taken = t;
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic both(input logic [2:0] pidx, input logic t, input logic [2:0] h,
                      input logic [2:0] uidx, input logic [2:0] uh, input logic ut);
    pred_valid = 1'b1;
    pred_idx   = pidx;
    expq.push_back({t, h});
    upd_valid  = 1'b1;
    upd_idx    = uidx;
    upd_hist   = uh;
    upd_taken  = ut;
    cyc();
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    chk(name, n, 64);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_out_valid"}, {31'd0, pred_out_valid}, 0);
    chk({tag, "_taken"},     {31'd0, pred_taken}, 0);
    chk({tag, "_hist"},      {29'd0, pred_hist}, 0);
    chk({tag, "_ready"},     {31'd0, ready}, 0);
  endtask

  initial begin
    rst_n = 1'b0; pred_valid = 1'b0; pred_idx = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_hist = '0; upd_taken = 1'b0;
    #12;
    chk_cleared("reset");
    cyc();
    rst_n = 1'b1;
    // Requests during INIT must be ignored.
    pred_valid = 1'b1; pred_idx = 3'd5;
    upd_valid = 1'b1; upd_idx = 3'd5; upd_hist = 3'd0; upd_taken = 1'b1;
    wait_ready("init_cycles");
    pred_valid = 1'b0; upd_valid = 1'b0;

    for (int i = 0; i < 8; i++) pred(3'(i), 1'b0, 3'b000);

    // Training index 5
    upd(5, 3'b000, 1); pred(5, 0, 3'b001);
    upd(5, 3'b001, 1); pred(5, 0, 3'b011);
    upd(5, 3'b011, 1); pred(5, 0, 3'b111);
    upd(5, 3'b111, 1); pred(5, 1, 3'b111);

    // Saturation at the top: {111,5} 10 -> 11, then one NT gives 10
    for (int i = 0; i < 6; i++) upd(5, 3'b111, 1);
    upd(5, 3'b111, 0);
    upd(5, 3'b110, 1); upd(5, 3'b101, 1); upd(5, 3'b011, 1);
    pred(5, 1, 3'b111);
    upd(5, 3'b111, 0);
    upd(5, 3'b110, 1); upd(5, 3'b101, 1); upd(5, 3'b011, 1);
    pred(5, 0, 3'b111);

    // Clamp at zero: {000,1} 01 -> 00 x3, then +2 gives 10
    for (int i = 0; i < 3; i++) upd(1, 3'b000, 0);
    upd(1, 3'b000, 1); upd(1, 3'b000, 1);
    for (int i = 0; i < 3; i++) upd(1, 3'b111, 0);
    pred(1, 1, 3'b000);

    // Stale history: update trains {000,2} although BHT[2] has moved on
    pred(2, 0, 3'b000);
    upd(2, 3'b110, 1); upd(2, 3'b110, 1);
    upd(2, 3'b000, 1);
    pred(2, 0, 3'b111);
    for (int i = 0; i < 3; i++) upd(2, 3'b101, 0);
    pred(2, 1, 3'b000);

    // Same-cycle collision, history forwarding
`ifdef BP_BYPASS_EN
    both(3, 0, 3'b001, 3, 3'b000, 1);
`else
    both(3, 0, 3'b000, 3, 3'b000, 1);
`endif
    pred(3, 0, 3'b001);

    // Same-cycle collision, counter forwarding ({000,4} 10 -> 01)
    upd(4, 3'b000, 1);
    for (int i = 0; i < 3; i++) upd(4, 3'b111, 0);
`ifdef BP_BYPASS_EN
    both(4, 0, 3'b000, 4, 3'b000, 0);
`else
    both(4, 1, 3'b000, 4, 3'b000, 0);
`endif
    pred(4, 0, 3'b000);

    // Outputs hold while pred_out_valid is low
    upd(5, 3'b111, 1);
    pred(5, 1, 3'b111);
    cyc();
    chk("hold_out_valid", {31'd0, pred_out_valid}, 0);
    chk("hold_taken",     {31'd0, pred_taken}, 1);
    chk("hold_hist",      {29'd0, pred_hist}, 3'b111);

    // Reset mid-operation, then mid-sweep
    rst_n = 1'b0;
    #1;
    chk_cleared("rst_midop");
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    chk("sweep30_ready", {31'd0, ready}, 0);
    rst_n = 1'b0;
    #1;
    chk_cleared("rst_midsweep");
    cyc();
    rst_n = 1'b1;
    wait_ready("reinit_cycles");
    pred(5, 0, 3'b000);

    cyc(); cyc(); cyc();
    chk("queue_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
